// File: rtl/latch_stim_gen.sv
// Stimulus generator driving the data and gate of a level-sensitive D latch.
// Produces repeatable gate windows of programmable period/high time, with the
// data change placed at a chosen phase (inside or outside the transparent window).
//
// Ports:
//   clk, rst_n      system clock, asynchronous active-low reset
//   start, stop     run request (IDLE only) / abort request (RUN only)
//   period          window length in clk cycles (>= 2)
//   high_time       gate-high cycles per window
//   d_phase         phase at which d_out updates
//   mode            d source: 00 toggle, 01 LFSR, 1x constant d_const
//   d_const         constant-mode data value
//   num_windows     windows to run, 0 = until stop
//   d_out, gate_out latch data and enable
//   busy, done      run in progress / one-cycle completion pulse
//   cfg_err         one-cycle pulse when start is rejected
//   win_cnt         completed windows in current/last run
module latch_stim_gen #(
   parameter int unsigned          CNT_W  = 8,
   parameter int unsigned          LFSR_W = 8,
   parameter logic [LFSR_W-1:0]    SEED   = 8'hA5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] high_time,
   input  logic [CNT_W-1:0] d_phase,
   input  logic [1:0]       mode,
   input  logic             d_const,
   input  logic [CNT_W-1:0] num_windows,
   output logic             d_out,
   output logic             gate_out,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic [CNT_W-1:0] win_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t              state, state_n;
   logic [CNT_W-1:0]    phase, phase_n;
   logic [CNT_W-1:0]    win_cnt_n;
   logic [LFSR_W-1:0]   lfsr, lfsr_n;
   logic                d_n, gate_n, busy_n, done_n, cfg_err_n;
   logic [CNT_W-1:0]    per_q, ht_q, dph_q, num_q;
   logic [CNT_W-1:0]    per_n, ht_n, dph_n, num_n;
   logic [1:0]          mode_q, mode_n;
   logic                dc_q, dc_n;

   // Helper signals for the "enter a phase" update shared by SETUP and RUN
   logic                do_enter;
   logic [CNT_W-1:0]    enter_p;
   logic [LFSR_W-1:0]   lfsr_base, lfsr_next;
   logic [CNT_W-1:0]    eff_ht, eff_dph;
   logic [1:0]          eff_mode;
   logic                eff_dc;
   logic                wrap, final_wrap;
   logic [CNT_W-1:0]    win_inc;

   // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         phase    <= '0;
         win_cnt  <= '0;
         lfsr     <= SEED;
         d_out    <= 1'b0;
         gate_out <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
         per_q    <= '0;
         ht_q     <= '0;
         dph_q    <= '0;
         num_q    <= '0;
         mode_q   <= '0;
         dc_q     <= 1'b0;
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         win_cnt  <= win_cnt_n;
         lfsr     <= lfsr_n;
         d_out    <= d_n;
         gate_out <= gate_n;
         busy     <= busy_n;
         done     <= done_n;
         cfg_err  <= cfg_err_n;
         per_q    <= per_n;
         ht_q     <= ht_n;
         dph_q    <= dph_n;
         num_q    <= num_n;
         mode_q   <= mode_n;
         dc_q     <= dc_n;
      end
   end

   // During SETUP the shadow registers are being loaded, so use the live inputs
   always_comb begin
      eff_ht    = (state == S_SETUP) ? high_time : ht_q;
      eff_dph   = (state == S_SETUP) ? d_phase   : dph_q;
      eff_mode  = (state == S_SETUP) ? mode      : mode_q;
      eff_dc    = (state == S_SETUP) ? d_const   : dc_q;
      lfsr_base = (state == S_SETUP) ? SEED      : lfsr;
      lfsr_next = lfsr_step(lfsr_base);
      wrap       = (phase == CNT_W'(per_q - CNT_W'(1)));
      win_inc    = (win_cnt == CNT_MAX) ? win_cnt : CNT_W'(win_cnt + CNT_W'(1));
      final_wrap = wrap && (num_q != '0) && (win_inc == num_q);
   end

   // Next-state and next-output logic
   always_comb begin
      state_n   = state;
      phase_n   = phase;
      win_cnt_n = win_cnt;
      lfsr_n    = lfsr;
      d_n       = d_out;
      gate_n    = gate_out;
      busy_n    = busy;
      done_n    = 1'b0;
      cfg_err_n = 1'b0;
      per_n     = per_q;
      ht_n      = ht_q;
      dph_n     = dph_q;
      num_n     = num_q;
      mode_n    = mode_q;
      dc_n      = dc_q;
      do_enter  = 1'b0;
      enter_p   = '0;

      case (state)
         S_IDLE: begin
            gate_n = 1'b0;
            if (start) begin
               if (period >= CNT_W'(2)) begin
                  state_n = S_SETUP;
                  busy_n  = 1'b1;
               end else begin
                  cfg_err_n = 1'b1;
               end
            end
         end
         S_SETUP: begin
            per_n     = period;
            ht_n      = high_time;
            dph_n     = d_phase;
            num_n     = num_windows;
            mode_n    = mode;
            dc_n      = d_const;
            win_cnt_n = '0;
            lfsr_n    = SEED;
            do_enter  = 1'b1;
            enter_p   = '0;
            state_n   = S_RUN;
         end
         S_RUN: begin
            if (final_wrap || stop) begin
               if (final_wrap) win_cnt_n = win_inc;
               state_n = S_DONE;
               gate_n  = 1'b0;
               busy_n  = 1'b0;
               done_n  = 1'b1;
            end else if (wrap) begin
               win_cnt_n = win_inc;
               do_enter  = 1'b1;
               enter_p   = '0;
            end else begin
               do_enter = 1'b1;
               enter_p  = CNT_W'(phase + CNT_W'(1));
            end
         end
         S_DONE: begin
            gate_n  = 1'b0;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase

      // Entering a phase: gate level and optional data update
      if (do_enter) begin
         phase_n = enter_p;
         gate_n  = (enter_p < eff_ht);
         if (enter_p == eff_dph) begin
            case (eff_mode)
               2'b00:   d_n = ~d_out;
               2'b01: begin
                  lfsr_n = lfsr_next;
                  d_n    = lfsr_next[0];
               end
               default: d_n = eff_dc;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_latch_stim_gen.sv
// Self-checking bench for latch_stim_gen: directed and random runs compared
// against an arithmetic model of window phase, gate level and data updates.
module tb_latch_stim_gen;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, stop, d_const;
   logic [7:0] period, high_time, d_phase, num_windows;
   logic [1:0] mode;
   logic       d_out, gate_out, busy, done, cfg_err;
   logic [7:0] win_cnt;

   int total = 0;
   int bad   = 0;
   logic d_exp = 1'b0;

   latch_stim_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
      .period(period), .high_time(high_time), .d_phase(d_phase),
      .mode(mode), .d_const(d_const), .num_windows(num_windows),
      .d_out(d_out), .gate_out(gate_out), .busy(busy), .done(done),
      .cfg_err(cfg_err), .win_cnt(win_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Bit 0 of the LFSR after k shifts from the seed (poly x^8+x^6+x^5+x^4+1)
   function automatic logic lfsr_bit(input int k);
      logic [7:0] l = 8'hA5;
      for (int i = 0; i < k; i++) l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      return l[0];
   endfunction

   // Expected d_out in RUN cycle n, given d_out before the run (d0)
   function automatic logic d_model(input int n, input int per, input int dph,
                                    input int md, input logic dc, input logic d0);
      int cnt;
      cnt = (dph < per && n >= dph) ? (n - dph) / per + 1 : 0;
      if (cnt == 0) return d0;
      case (md)
         0:       return d0 ^ logic'(cnt % 2);
         1:       return lfsr_bit(cnt);
         default: return dc;
      endcase
   endfunction

   // One complete run; stop_at is the RUN cycle in which stop is held (-1: none)
   task automatic run_cfg(input int per, input int ht, input int dph, input int md,
                          input logic dc, input int num, input int stop_at, input bit poke);
      int   len, wfin;
      logic d0;
      d0 = d_exp;
      period = 8'(per); high_time = 8'(ht); d_phase = 8'(dph);
      mode = 2'(md); d_const = dc; num_windows = 8'(num);
      if (num == 0) len = stop_at + 1;
      else if (stop_at >= 0 && stop_at < num * per) len = stop_at + 1;
      else len = num * per;
      wfin = (num != 0 && len == num * per) ? num : stop_at / per;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("setup_busy", 32'(busy), 1);
      chk("setup_gate", 32'(gate_out), 0);
      chk("setup_done", 32'(done), 0);
      for (int n = 0; n < len; n++) begin
         @(negedge clk);
         chk("run_gate", 32'(gate_out), 32'((n % per) < ht));
         chk("run_d", 32'(d_out), 32'(d_model(n, per, dph, md, dc, d0)));
         chk("run_win", 32'(win_cnt), 32'(n / per));
         chk("run_busy", 32'(busy), 1);
         chk("run_done", 32'(done), 0);
         if (poke && n == 2) begin
            start = 1'b1; period = 8'd3; high_time = 8'd0; d_phase = 8'd1;
         end
         if (poke && n == 3) start = 1'b0;
         if (n == stop_at) stop = 1'b1;
      end
      @(negedge clk);
      stop = 1'b0;
      d_exp = d_model(len - 1, per, dph, md, dc, d0);
      chk("done_pulse", 32'(done), 1);
      chk("done_busy", 32'(busy), 0);
      chk("done_gate", 32'(gate_out), 0);
      chk("done_win", 32'(win_cnt), 32'(wfin));
      chk("done_d", 32'(d_out), 32'(d_exp));
      @(negedge clk);
      chk("idle_done", 32'(done), 0);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_gate", 32'(gate_out), 0);
      chk("idle_win", 32'(win_cnt), 32'(wfin));
      chk("idle_d", 32'(d_out), 32'(d_exp));
   endtask

   task automatic reject(input int per);
      period = 8'(per);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("rej_err", 32'(cfg_err), 1);
      chk("rej_busy", 32'(busy), 0);
      @(negedge clk);
      chk("rej_err_clr", 32'(cfg_err), 0);
      chk("rej_busy2", 32'(busy), 0);
   endtask

   initial begin
      int per, ht, dph, md, num, sa;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; d_const = 1'b0;
      period = 8'd8; high_time = 8'd4; d_phase = 8'd2; mode = 2'd0; num_windows = 8'd3;
      #12;
      chk("rst_gate", 32'(gate_out), 0);
      chk("rst_d", 32'(d_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_win", 32'(win_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run_cfg(8, 4, 2, 0, 1'b0, 3, -1, 1'b0);   // transparent-window toggle
      run_cfg(10, 3, 6, 2, 1'b1, 2, -1, 1'b0);  // change in hold window
      run_cfg(2, 1, 0, 1, 1'b0, 8, -1, 1'b0);   // LFSR sequence
      run_cfg(2, 1, 0, 1, 1'b0, 8, -1, 1'b0);   // rerun, same sequence
      run_cfg(6, 0, 1, 0, 1'b0, 2, -1, 1'b0);   // gate never high
      run_cfg(8, 20, 3, 0, 1'b0, 2, -1, 1'b0);  // gate always high
      run_cfg(8, 4, 2, 0, 1'b0, 0, 21, 1'b0);   // stop at phase 5 of window 2
      run_cfg(8, 4, 2, 0, 1'b0, 2, -1, 1'b1);   // start during RUN ignored
      run_cfg(4, 2, 1, 1, 1'b0, 2, 7, 1'b0);    // stop on the final wrap
      run_cfg(5, 2, 9, 0, 1'b0, 2, -1, 1'b0);   // d_phase beyond period
      run_cfg(3, 3, 2, 3, 1'b1, 2, -1, 1'b0);   // reserved mode acts as constant
      reject(1);
      reject(0);

      for (int r = 0; r < 25; r++) begin
         per = 2 + int'($urandom_range(0, 7));
         ht  = int'($urandom_range(0, 11));
         dph = int'($urandom_range(0, 10));
         md  = int'($urandom_range(0, 3));
         num = int'($urandom_range(0, 3));
         if (num == 0) sa = int'($urandom_range(0, 19));
         else if ($urandom_range(0, 2) == 0) sa = int'($urandom_range(0, num * per - 1));
         else sa = -1;
         run_cfg(per, ht, dph, md, 1'($urandom_range(0, 1)), num, sa,
                 1'($urandom_range(0, 1)));
      end

      // Asynchronous reset in window 1 phase 0 while the gate is high
      period = 8'd8; high_time = 8'd4; d_phase = 8'd0; mode = 2'd2; d_const = 1'b1;
      num_windows = 8'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int n = 0; n <= 8; n++) @(negedge clk);
      chk("pre_rst_gate", 32'(gate_out), 1);
      chk("pre_rst_win", 32'(win_cnt), 1);
      chk("pre_rst_d", 32'(d_out), 1);
      rst_n = 1'b0;
      #1;
      chk("arst_gate", 32'(gate_out), 0);
      chk("arst_d", 32'(d_out), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_win", 32'(win_cnt), 0);
      chk("arst_done", 32'(done), 0);
      @(negedge clk);
      chk("arst_nodone", 32'(done), 0);
      rst_n = 1'b1;
      d_exp = 1'b0;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);
      run_cfg(4, 2, 1, 0, 1'b0, 2, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
